// File: rtl/cskip_pkg.sv
// Shared definitions for the carry-skip sequential adder controller.
package cskip_pkg;

    localparam int SLICE_W    = 4;
    localparam int SKIP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cskip_state_t;

endpackage

// File: rtl/cskip_slice.sv
// One 4-bit carry-skip slice: ripple sum always, carry bypassed when all bits propagate.
module cskip_slice
    import cskip_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               p
);

    logic [SLICE_W:0] ripple;

    assign ripple = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};
    assign p      = &(a ^ b);
    assign s      = ripple[SLICE_W-1:0];
    assign co     = p ? ci : ripple[SLICE_W];

endmodule

// File: rtl/cskip_seq_add_ctrl.sv
// Multi-cycle WIDTH-bit adder scheduler around one shared carry-skip slice.
// Optional skip counter output o_skip_cnt is built when CSKIP_SKIP_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand request, o_ready high
// RUN   | evaluating slice k this cycle, carry kept in carry_q
// DONE  | result held on sum/cout with o_valid high until i_ready
module cskip_seq_add_ctrl
    import cskip_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSKIP_SKIP_CNT_EN
    ,
    output logic [SKIP_CNT_W-1:0] o_skip_cnt
`endif
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_chk
            $error("cskip_seq_add_ctrl: WIDTH must be a positive multiple of SLICE_W");
        end
    endgenerate

    cskip_state_t       state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_b_q, sum_q;
    logic               carry_q, cout_q;
    logic [CNT_W-1:0]   k_q;
    logic               last_slice;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co, slice_p;

    assign last_slice = (k_q == CNT_W'(NSLICE - 1));

    cskip_slice u_slice (
        .a  (op_a_q[k_q*SLICE_W +: SLICE_W]),
        .b  (op_b_q[k_q*SLICE_W +: SLICE_W]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co),
        .p  (slice_p)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; a DONE handoff always passes through IDLE before the next accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid)    state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (i_ready)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        o_ready = (state_q == IDLE) && !i_rst;
        o_valid = (state_q == DONE);
    end

    // Operand latch, per-slice sum write-back and inter-slice carry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        op_a_q  <= i_add_term1;
                        op_b_q  <= i_add_term2;
                        carry_q <= i_cin;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    sum_q[k_q*SLICE_W +: SLICE_W] <= slice_s;
                    carry_q                       <= slice_co;
                    if (last_slice) cout_q <= slice_co;
                    else            k_q    <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef CSKIP_SKIP_CNT_EN
    logic [SKIP_CNT_W-1:0] skip_cnt_q;

    // Count propagating slices; saturates and only reset clears it
    always_ff @(posedge i_clk) begin
        if (i_rst)
            skip_cnt_q <= '0;
        else if (state_q == RUN && slice_p && skip_cnt_q != {SKIP_CNT_W{1'b1}})
            skip_cnt_q <= skip_cnt_q + 1'b1;
    end

    assign o_skip_cnt = skip_cnt_q;
`else
    logic skip_p_unused;
    assign skip_p_unused = slice_p;
`endif

endmodule
